// File: rtl/bitpacker_pkg.sv
// bitpacker_pkg: shared widths, scheduler state and MCU interleave maps
package bitpacker_pkg;
  localparam int WORD_W = 32;
  localparam int WIDTH_W = 6;
  typedef enum logic [1:0] {RUN, PAD, DONE} sched_state_t;
  localparam logic [11:0] SEQ_MAP_420 = {2'd2, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0};
  localparam logic [5:0] SEQ_MAP_444 = {2'd2, 2'd1, 2'd0};
endpackage

// File: rtl/bitpacker_pad_gen.sv
// bitpacker_pad_gen: maps the stream bit offset to the 1-bit padding beat that reaches a byte boundary
module bitpacker_pad_gen
  import bitpacker_pkg::*;
(
  input  logic [2:0]         bit_mod8,
  output logic [WIDTH_W-1:0] pad_width,
  output logic [WORD_W-1:0]  pad_data
);
  logic [2:0] pad;
  logic [7:0] ones;
  assign pad = 3'd0 - bit_mod8;
  assign ones = 8'hFF >> (4'd8 - {1'b0, pad});
  assign pad_width = WIDTH_W'(pad);
  assign pad_data = WORD_W'(ones);
endmodule

// File: rtl/bitpacker_scheduler.sv
// bitpacker_scheduler: grants the shared bitpacker to Y/Cb/Cr encoder lanes in MCU order and byte-pads at frame end
// Optional: define BITPACKER_SCHED_FRAME_BITS_EN to add the frame_bits output (total bits of the last frame, padding included).
module bitpacker_scheduler
  import bitpacker_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int SEQ_LEN = 6,
  parameter logic [2*SEQ_LEN-1:0] SEQ_MAP = SEQ_MAP_420
) (
  input  logic                       clock,
  input  logic                       nreset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WORD_W-1:0]  req_data,
  input  logic [NUM_REQ*WIDTH_W-1:0] req_width,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       frame_end,
  output logic                       bp_data_in_valid,
  output logic [WORD_W-1:0]          bp_data_in,
  output logic [WIDTH_W-1:0]         bp_input_width,
  output logic                       flush_done,
  output logic [15:0]                mcu_count,
`ifdef BITPACKER_SCHED_FRAME_BITS_EN
  output logic [31:0]                frame_bits,
`endif
  output logic                       protocol_err
);
  localparam int SLOT_W = SEQ_LEN > 1 ? $clog2(SEQ_LEN) : 1;
  sched_state_t state, state_nx;
  logic [SLOT_W-1:0] slot, slot_nx;
  logic in_block, blk_nx, flush_pending;
  logic [2:0] bit_mod8;
  logic [1:0] sel;
  logic [WORD_W-1:0] data_a [NUM_REQ];
  logic [WIDTH_W-1:0] width_a [NUM_REQ];
  logic [WORD_W-1:0] pad_data;
  logic [WIDTH_W-1:0] pad_w, width_s, width_c, add_w;
  logic xfer, last_s, beat, pad_beat, slot_end, mcu_end;
  assign sel = SEQ_MAP[{slot, 1'b0} +: 2];
  // Unpack the flat lane buses so the granted lane can be indexed directly.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      data_a[i] = req_data[i*WORD_W +: WORD_W];
      width_a[i] = req_width[i*WIDTH_W +: WIDTH_W];
    end
  end
  assign width_s = width_a[sel];
  assign last_s = req_last[sel];
  assign xfer = state == RUN && req_valid[sel];
  assign width_c = width_s > 6'd32 ? 6'd32 : width_s;
  assign beat = xfer && width_s != '0;
  assign pad_beat = state == PAD && pad_w != '0;
  assign add_w = beat ? width_c : pad_beat ? pad_w : '0;
  assign slot_end = xfer && last_s;
  assign mcu_end = slot_end && slot == SLOT_W'(SEQ_LEN - 1);
  assign slot_nx = slot_end ? (mcu_end ? '0 : slot + 1'b1) : slot;
  assign blk_nx = xfer ? !last_s : in_block;
  bitpacker_pad_gen u_pad_gen (
    .bit_mod8  (bit_mod8),
    .pad_width (pad_w),
    .pad_data  (pad_data)
  );
  // State register.
  always_ff @(posedge clock or negedge nreset)
    if (!nreset) state <= RUN;
    else state <= state_nx;
  // Flush is taken once the post-transfer position is an MCU boundary, so a pulse coinciding with the MCU-closing beat still counts.
  always_comb begin
    state_nx = state;
    case (state)
      RUN:     state_nx = (flush_pending || frame_end) && slot_nx == '0 && !blk_nx ? PAD : RUN;
      PAD:     state_nx = DONE;
      default: state_nx = RUN;
    endcase
  end
  // Grant follows the slot map only while running; held low during reset.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) req_ready[i] = nreset && state == RUN && sel == 2'(i);
  end
  // Slot tracking, counters and the registered bitpacker beat.
  always_ff @(posedge clock or negedge nreset)
    if (!nreset) begin
      slot <= '0;
      in_block <= 1'b0;
      flush_pending <= 1'b0;
      mcu_count <= '0;
      protocol_err <= 1'b0;
      bit_mod8 <= '0;
      bp_data_in_valid <= 1'b0;
      bp_data_in <= '0;
      bp_input_width <= '0;
      flush_done <= 1'b0;
    end else begin
      slot <= slot_nx;
      in_block <= blk_nx;
      flush_pending <= state == DONE ? 1'b0 : flush_pending | frame_end;
      mcu_count <= state == DONE ? '0 : mcu_count + 16'(mcu_end);
      protocol_err <= protocol_err | (xfer && width_s > 6'd32);
      bit_mod8 <= state == DONE ? '0 : bit_mod8 + add_w[2:0];
      bp_data_in_valid <= beat | pad_beat;
      if (beat | pad_beat) begin
        bp_data_in <= beat ? data_a[sel] : pad_data;
        bp_input_width <= add_w;
      end
      flush_done <= state == DONE;
    end
`ifdef BITPACKER_SCHED_FRAME_BITS_EN
  logic [31:0] bits_cnt;
  logic [32:0] bits_sum;
  assign bits_sum = {1'b0, bits_cnt} + 33'(add_w);
  // Saturating frame bit count, snapshotted into frame_bits and cleared on DONE.
  always_ff @(posedge clock or negedge nreset)
    if (!nreset) begin
      bits_cnt <= '0;
      frame_bits <= '0;
    end else if (state == DONE) begin
      frame_bits <= bits_cnt;
      bits_cnt <= '0;
    end else bits_cnt <= bits_sum[32] ? '1 : bits_sum[31:0];
`endif
endmodule

// File: tb/tb_bitpacker_scheduler.sv
// tb_bitpacker_scheduler: table vectors, directed corner sequences and random traffic against a reference model
module tb_bitpacker_scheduler;
  logic clock = 1'b0, nreset = 1'b0;
  logic [2:0] req_valid = '0, req_last = '0, req_ready;
  logic [95:0] req_data = '0;
  logic [17:0] req_width = '0;
  logic frame_end = 1'b0, bp_data_in_valid, flush_done, protocol_err;
  logic [31:0] bp_data_in;
  logic [5:0] bp_input_width;
  logic [15:0] mcu_count;
  int n_cmp = 0, n_bad = 0;
  int map [6] = '{0, 0, 0, 0, 1, 2};
  int m_slot, m_phase, m_mcu;
  bit m_inblk, m_pend, m_err, e_valid, e_fd;
  longint m_bits;
  logic [31:0] e_data;
  logic [5:0] e_width;
  typedef struct {
    logic [2:0] v, l;
    logic fe;
    logic [2:0] rdy;
    logic bv;
    logic [5:0] bw;
    logic [31:0] bd;
    logic fd;
    logic [15:0] mcu;
  } vec_t;
  vec_t tbl [16];

  always #5 clock = ~clock;

  bitpacker_scheduler dut (
    .clock            (clock),
    .nreset           (nreset),
    .req_valid        (req_valid),
    .req_data         (req_data),
    .req_width        (req_width),
    .req_last         (req_last),
    .req_ready        (req_ready),
    .frame_end        (frame_end),
    .bp_data_in_valid (bp_data_in_valid),
    .bp_data_in       (bp_data_in),
    .bp_input_width   (bp_input_width),
    .flush_done       (flush_done),
    .mcu_count        (mcu_count),
    .protocol_err     (protocol_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_slot = 0; m_phase = 0; m_mcu = 0; m_inblk = 0; m_pend = 0; m_err = 0; m_bits = 0;
    e_valid = 0; e_fd = 0; e_data = '0; e_width = '0;
  endtask

  task automatic do_reset();
    nreset = 1'b0; req_valid = '0; req_last = '0; frame_end = 1'b0;
    m_reset();
    @(posedge clock);
    #1 nreset = 1'b1;
  endtask

  // One cycle: drive, check the grant, advance the model, check the registered outputs.
  task automatic step(input logic [2:0] v, input logic [2:0] l, input logic [17:0] w, input logic fe);
    int lane, wd, pad;
    lane = map[m_slot];
    req_valid = v; req_last = l; req_width = w; frame_end = fe;
    for (int i = 0; i < 3; i++) req_data[i*32 +: 32] = $urandom;
    #1 chk("ready", req_ready, m_phase == 0 ? 3'(1 << lane) : 3'd0);
    e_valid = 0;
    e_fd = m_phase == 2;
    if (m_phase == 0 && v[lane]) begin
      wd = int'(w[lane*6 +: 6]);
      if (wd > 32) begin wd = 32; m_err = 1; end
      if (wd > 0) begin
        e_valid = 1; e_data = req_data[lane*32 +: 32]; e_width = 6'(wd); m_bits += wd;
      end
      if (l[lane]) begin
        m_inblk = 0; m_slot++;
        if (m_slot == 6) begin m_slot = 0; m_mcu = (m_mcu + 1) % 65536; end
      end else m_inblk = 1;
    end
    if (m_phase == 1) begin
      pad = int'((8 - m_bits % 8) % 8);
      if (pad > 0) begin
        e_valid = 1; e_data = (32'd1 << pad) - 1; e_width = 6'(pad); m_bits += pad;
      end
      m_phase = 2;
    end else if (m_phase == 2) begin
      m_pend = 0; m_mcu = 0; m_bits = 0; m_phase = 0;
    end else begin
      m_pend |= fe;
      if (m_pend && m_slot == 0 && !m_inblk) m_phase = 1;
    end
    @(posedge clock);
    #1;
    chk("bp_valid", bp_data_in_valid, e_valid);
    chk("bp_data", bp_data_in, e_data);
    chk("bp_width", bp_input_width, e_width);
    chk("flush_done", flush_done, e_fd);
    chk("mcu_count", mcu_count, m_mcu);
    chk("protocol_err", protocol_err, m_err);
  endtask

  initial begin
    int lane;
    #2;
    chk("rst_ready", req_ready, 0);
    chk("rst_bp_valid", bp_data_in_valid, 0);
    chk("rst_mcu", mcu_count, 0);
    chk("rst_err", protocol_err, 0);
    chk("rst_fd", flush_done, 0);

    // Interleave two 5-bit codewords per block, then flush with 4-bit padding.
    for (int k = 0; k < 12; k++) begin
      lane = k < 8 ? 0 : k < 10 ? 1 : 2;
      tbl[k] = '{v: 3'b111, l: (k % 2 == 1) ? 3'b111 : 3'b000, fe: 1'b0, rdy: 3'(1 << lane),
                 bv: 1'b1, bw: 6'd5, bd: 32'(k * 4 + lane), fd: 1'b0, mcu: 16'(k == 11)};
    end
    tbl[12] = '{3'b000, 3'b000, 1'b1, 3'b001, 1'b0, 6'd5, 32'd46, 1'b0, 16'd1};
    tbl[13] = '{3'b111, 3'b000, 1'b0, 3'b000, 1'b1, 6'd4, 32'hF, 1'b0, 16'd1};
    tbl[14] = '{3'b111, 3'b000, 1'b0, 3'b000, 1'b0, 6'd4, 32'hF, 1'b1, 16'd0};
    tbl[15] = '{3'b000, 3'b000, 1'b0, 3'b001, 1'b0, 6'd4, 32'hF, 1'b0, 16'd0};
    do_reset();
    for (int k = 0; k < 16; k++) begin
      req_valid = tbl[k].v; req_last = tbl[k].l; frame_end = tbl[k].fe;
      req_width = {6'd5, 6'd5, 6'd5};
      for (int i = 0; i < 3; i++) req_data[i*32 +: 32] = 32'(k * 4 + i);
      #1 chk($sformatf("tbl%0d_ready", k), req_ready, tbl[k].rdy);
      @(posedge clock);
      #1;
      chk($sformatf("tbl%0d_bv", k), bp_data_in_valid, tbl[k].bv);
      chk($sformatf("tbl%0d_bw", k), bp_input_width, tbl[k].bw);
      chk($sformatf("tbl%0d_bd", k), bp_data_in, tbl[k].bd);
      chk($sformatf("tbl%0d_fd", k), flush_done, tbl[k].fd);
      chk($sformatf("tbl%0d_mcu", k), mcu_count, tbl[k].mcu);
    end

    // 43-bit MCU leaves offset 3: pad beat of 5 ones, flush_done two cycles after PAD entry.
    do_reset();
    step(3'b111, 3'b111, {6'd0, 6'd0, 6'd3}, 1'b0);
    for (int s = 1; s < 6; s++) step(3'b111, 3'b111, {6'd8, 6'd8, 6'd8}, 1'b0);
    step(3'b000, 3'b000, '0, 1'b1);
    step(3'b000, 3'b000, '0, 1'b0);
    chk("pad_width", bp_input_width, 5);
    chk("pad_data", bp_data_in, 32'h1F);
    step(3'b000, 3'b000, '0, 1'b0);
    chk("pad_fd", flush_done, 1);
    chk("pad_mcu", mcu_count, 0);

    // Byte-aligned 16-bit MCU: no pad beat, flush_done still pulses.
    do_reset();
    step(3'b111, 3'b111, {6'd4, 6'd4, 6'd4}, 1'b0);
    step(3'b111, 3'b111, {6'd4, 6'd4, 6'd4}, 1'b0);
    for (int s = 2; s < 6; s++) step(3'b111, 3'b111, {6'd2, 6'd2, 6'd2}, 1'b0);
    step(3'b000, 3'b000, '0, 1'b1);
    step(3'b000, 3'b000, '0, 1'b0);
    chk("aligned_no_pad", bp_data_in_valid, 0);
    step(3'b000, 3'b000, '0, 1'b0);
    chk("aligned_fd", flush_done, 1);

    // frame_end in the middle of slot 3: slots 3..5 finish before PAD.
    do_reset();
    for (int s = 0; s < 3; s++) step(3'b111, 3'b111, {6'd7, 6'd7, 6'd7}, 1'b0);
    step(3'b111, 3'b000, {6'd7, 6'd7, 6'd7}, 1'b1);
    for (int s = 3; s < 6; s++) step(3'b111, 3'b111, {6'd7, 6'd7, 6'd7}, 1'b0);
    chk("mid_mcu", mcu_count, 1);
    step(3'b111, 3'b111, {6'd7, 6'd7, 6'd7}, 1'b0);
    step(3'b111, 3'b111, {6'd7, 6'd7, 6'd7}, 1'b0);
    chk("mid_fd", flush_done, 1);

    // Lane 0 stalls while lanes 1 and 2 are valid; then width 0 and width 40.
    do_reset();
    for (int c = 0; c < 10; c++) step(3'b110, 3'b110, {6'd9, 6'd9, 6'd9}, 1'b0);
    chk("stall_ready", req_ready, 3'b001);
    step(3'b001, 3'b000, '0, 1'b0);
    chk("w0_no_beat", bp_data_in_valid, 0);
    step(3'b001, 3'b001, {6'd0, 6'd0, 6'd40}, 1'b0);
    chk("w40_width", bp_input_width, 32);
    chk("w40_err", protocol_err, 1);

    // Async reset while in PAD drops the pad beat; lane 0 is granted after release.
    do_reset();
    step(3'b111, 3'b111, {6'd3, 6'd3, 6'd3}, 1'b0);
    for (int s = 1; s < 6; s++) step(3'b111, 3'b111, '0, 1'b0);
    step(3'b000, 3'b000, '0, 1'b1);
    #2 nreset = 1'b0;
    #1;
    chk("rstpad_ready", req_ready, 0);
    chk("rstpad_bv", bp_data_in_valid, 0);
    chk("rstpad_bd", bp_data_in, 0);
    chk("rstpad_bw", bp_input_width, 0);
    chk("rstpad_mcu", mcu_count, 0);
    m_reset();
    @(posedge clock);
    #1;
    chk("rstpad_held_bv", bp_data_in_valid, 0);
    chk("rstpad_held_fd", flush_done, 0);
    nreset = 1'b1;
    step(3'b001, 3'b000, {6'd0, 6'd0, 6'd2}, 1'b0);

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic [2:0] v, l;
      logic [17:0] w;
      for (int i = 0; i < 3; i++) begin
        v[i] = ($urandom % 4) != 0;
        l[i] = ($urandom % 3) == 0;
        w[i*6 +: 6] = ($urandom % 60 == 0) ? 6'd40 : 6'($urandom_range(0, 32));
      end
      step(v, l, w, ($urandom % 40) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bitpacker_scheduler.md
Name: bitpacker_scheduler

Overview:
- Shares the single bitpacker between the per-component Huffman encoders (Y, Cb, Cr).
- Grants the bitpacker in fixed MCU interleave order and holds each grant for one whole block, until the codeword tagged last.
- At frame end, pads the stream with 1-bits up to a byte boundary, then reports completion.
- Sits between the entropy-coder lanes and the bitpacker input port.

Parameters:
- NUM_REQ, 3, number of requesting encoder lanes.
- SEQ_LEN, 6, blocks per MCU (6 = 4:2:0).
- SEQ_MAP, {2'd2,2'd1,2'd0,2'd0,2'd0,2'd0}, 2-bit requester index per slot; slot 0 is in the LSBs.

Ports:
- clock  in  1  system clock
- nreset  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  codeword valid, one bit per lane
- req_data  in  NUM_REQ*32  codeword per lane, LSB-aligned
- req_width  in  NUM_REQ*6  codeword bit length per lane, 0..32
- req_last  in  NUM_REQ  codeword is the last of its block
- req_ready  out  NUM_REQ  handshake accept, per lane
- frame_end  in  1  single-cycle pulse: flush after the current MCU
- bp_data_in_valid  out  1  to bitpacker data_in_valid
- bp_data_in  out  32  to bitpacker data_in
- bp_input_width  out  6  to bitpacker input_width
- flush_done  out  1  single-cycle pulse when padding has been issued
- mcu_count  out  16  MCUs completed in the current frame
- protocol_err  out  1  sticky: width >32 was seen

Behaviour:
- Reset (async, nreset=0) clears everything:
  - state=RUN, slot=0, bit_mod8=0, flush_pending=0, mcu_count=0, protocol_err=0.
  - All outputs are 0, req_ready included.
- Grant and handshake:
  - req_ready[i] = (state==RUN) && (SEQ_MAP[slot]==i). It never depends on req_valid.
  - Transfer occurs when req_valid[i] && req_ready[i].
- Bitpacker outputs are registered (one-cycle latency from the transfer):
  - bp_data_in_valid=1 on the following cycle, with that cycle's data and width.
  - Otherwise bp_data_in_valid=0; data and width hold their last value.
- Width rules:
  - width 0: the transfer completes (last still honoured), but no bitpacker beat is issued.
  - width >32: clamped to 32 and protocol_err is set.
  - bit_mod8 += width (mod 8) on each issued beat.
- Slot advance: a transfer with req_last=1 advances the slot.
  - When slot reaches SEQ_LEN-1 and completes, slot wraps to 0 and mcu_count increments. mcu_count wraps at 16'hFFFF.
- Flush request:
  - frame_end sets flush_pending. Any further pulse while pending is ignored.
  - A flush is taken only at an MCU boundary (slot==0 with no block in progress), either immediately or after the current MCU finishes.
  - If frame_end arrives in the same cycle as the transfer that closes the MCU, PAD is entered on the next cycle.
- States:
  - RUN: serves lanes as above. On flush_pending at an MCU boundary, goes to PAD.
  - PAD: for one cycle, req_ready is all 0.
    - pad = (8-bit_mod8)&7. If pad≠0, issues one beat: data = 32'hFF>>(8-pad) with high bits zero, width=pad.
    - Goes to DONE.
  - DONE: pulses flush_done=1 for one cycle; clears bit_mod8, mcu_count and flush_pending; returns to RUN with slot=0.
- Mid-block stall: a lane with req_valid=0 keeps the grant indefinitely. There is no timeout and no skipping.
- Reset during PAD or DONE: the pending beat and pulse are dropped; there is no partial output.

Optional Feature:
- Macro: BITPACKER_SCHED_FRAME_BITS_EN.
- Defined:
  - Adds output frame_bits[31:0], a running bit count that includes the padding.
  - The value is latched into frame_bits on the DONE cycle; the count then clears.
  - The internal counter saturates at 32'hFFFFFFFF.
  - frame_bits resets to 0.
- Undefined: the port is absent and only the 3-bit bit_mod8 is kept.

Decomposition:
- Package bitpacker_pkg holds:
  - WORD_W=32 and WIDTH_W=6.
  - sched_state_t enum {RUN, PAD, DONE}.
  - The default 4:2:0 SEQ_MAP constant, plus a 4:4:4 variant {2,1,0}.
- One natural sub-module: bitpacker_pad_gen. It is combinational and maps bit_mod8 to pad width and pad data.
- Everything else stays flat.

Test Plan:
- Interleave: give each lane one block of 2 codewords (width 5), lanes always valid → grant order 0,0,0,0,1,2; 12 beats; mcu_count=1; bit_mod8=4.
- Pad: 3-bit codeword, then frame_end → PAD beat with width=5, data=32'h1F; flush_done 2 cycles after PAD entry; mcu_count=0.
- Aligned flush: total of 16 bits, then frame_end → no pad beat; flush_done still pulses.
- Mid-MCU flush: frame_end during slot 3 → lanes 0,1,2 finish slots 3..5 first; then PAD.
- Stall and width edge cases: lane 0 idle for 10 cycles while lanes 1 and 2 are valid → req_ready stays only on lane 0; width 0 → no beat issued; width 40 → beat width 32 and protocol_err=1.
- Async reset asserted in PAD → all outputs are 0 immediately; after release, lane 0 is granted.
